// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares one single-port, 1-cycle-latency data memory between the core
// load/store port (c_*) and an external loader/debug port (x_*). At most one
// access is granted per cycle; read data is returned the following cycle.
//
// state     | meaning
// last_x    | 1 = external port owned the most recent grant, 0 = core
// wait_cnt  | consecutive cycles the core has been stalled (saturating)
// rsp_c/x   | a read granted last cycle returns its data this cycle

module dmem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_stall,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          x_req,
    input  logic          x_we,
    input  logic [AW-1:0] x_addr,
    input  logic [DW-1:0] x_wdata,
    input  logic          x_lock,
    output logic          x_gnt,
    output logic          x_rvalid,
    output logic [DW-1:0] x_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic       last_x, last_x_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    logic       rsp_c, rsp_x, rsp_c_nxt, rsp_x_nxt;
    logic       gnt_c, gnt_x;

    // State register; last owner resets to external so the core wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_x   <= 1'b1;
            wait_cnt <= '0;
            rsp_c    <= 1'b0;
            rsp_x    <= 1'b0;
        end else begin
            last_x   <= last_x_nxt;
            wait_cnt <= wait_cnt_nxt;
            rsp_c    <= rsp_c_nxt;
            rsp_x    <= rsp_x_nxt;
        end
    end

    // Grant selection: single requester, then core starvation limit, then external lock, then round-robin.
    always_comb begin
        gnt_c = 1'b0;
        gnt_x = 1'b0;
        if (rst) begin
            if (c_req && !x_req) begin
                gnt_c = 1'b1;
            end else if (x_req && !c_req) begin
                gnt_x = 1'b1;
            end else if (c_req && x_req) begin
                if (wait_cnt == WAIT_LIM)
                    gnt_c = 1'b1;
                else if (x_lock && last_x)
                    gnt_x = 1'b1;
                else if (last_x)
                    gnt_c = 1'b1;
                else
                    gnt_x = 1'b1;
            end
        end
    end

    // Next-state: owner tracking, core wait counter and one-cycle read response flags.
    always_comb begin
        last_x_nxt = last_x;
        if (gnt_c || gnt_x)
            last_x_nxt = gnt_x;
        wait_cnt_nxt = '0;
        if (c_req && !gnt_c)
            wait_cnt_nxt = (wait_cnt == WAIT_LIM) ? wait_cnt : wait_cnt + 4'd1;
        rsp_c_nxt = gnt_c && !c_we;
        rsp_x_nxt = gnt_x && !x_we;
    end

    // Outputs: grant strobes, memory mux from the winner, read data gated during reset.
    always_comb begin
        c_gnt    = gnt_c;
        x_gnt    = gnt_x;
        c_stall  = rst && c_req && !gnt_c;
        m_en     = gnt_c || gnt_x;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        if (gnt_c) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (gnt_x) begin
            m_we    = x_we;
            m_addr  = x_addr;
            m_wdata = x_wdata;
        end
        c_rvalid = rsp_c;
        x_rvalid = rsp_x;
        c_rdata  = rst ? m_rdata : '0;
        x_rdata  = rst ? m_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a behavioural model of the sharing rules.

module tb_dmem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          c_req = 1'b0, c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic          c_gnt, c_stall, c_rvalid;
    logic [DW-1:0] c_rdata;
    logic          x_req = 1'b0, x_we = 1'b0, x_lock = 1'b0;
    logic [AW-1:0] x_addr = '0;
    logic [DW-1:0] x_wdata = '0;
    logic          x_gnt, x_rvalid;
    logic [DW-1:0] x_rdata;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;

    dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_lock(x_lock), .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Environment memory: single port, synchronous read, 64 words indexed by low address bits.
    logic [DW-1:0] tb_mem [64];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) tb_mem[m_addr[5:0]] <= m_wdata;
            else      m_rdata <= tb_mem[m_addr[5:0]];
        end
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [64];
    bit            mdl_last_x;
    int            mdl_wait;
    bit            mdl_pend_c, mdl_pend_x;
    logic [DW-1:0] mdl_data_c, mdl_data_x;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic preload(input int idx, input logic [DW-1:0] d);
        tb_mem[idx]  = d;
        ref_mem[idx] = d;
    endtask

    task automatic model_reset();
        mdl_last_x = 1'b1;
        mdl_wait   = 0;
        mdl_pend_c = 1'b0;
        mdl_pend_x = 1'b0;
    endtask

    // Assert reset with both ports requesting; all outputs must read zero.
    task automatic do_reset();
        rst = 1'b0;
        c_req = 1'b1;
        x_req = 1'b1;
        #2;
        chk("rst_c_gnt", c_gnt, 0);
        chk("rst_x_gnt", x_gnt, 0);
        chk("rst_m_en", m_en, 0);
        chk("rst_c_stall", c_stall, 0);
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_x_rvalid", x_rvalid, 0);
        chk("rst_m_addr", m_addr, 0);
        @(posedge clk);
        #1;
        chk("rst_m_we", m_we, 0);
        chk("rst_c_rdata", c_rdata, 0);
        model_reset();
        rst = 1'b1;
    endtask

    // One bus cycle: predict, check at the falling edge, advance the model at the rising edge.
    task automatic cycle(output bit eg_c, output bit eg_x);
        logic [AW-1:0] ea;
        eg_c = 1'b0;
        eg_x = 1'b0;
        if (c_req && !x_req)           eg_c = 1'b1;
        else if (x_req && !c_req)      eg_x = 1'b1;
        else if (c_req && x_req) begin
            if (mdl_wait == MAX_WAIT)        eg_c = 1'b1;
            else if (x_lock && mdl_last_x)   eg_x = 1'b1;
            else if (mdl_last_x)             eg_c = 1'b1;
            else                             eg_x = 1'b1;
        end
        ea = eg_c ? c_addr : (eg_x ? x_addr : '0);
        @(negedge clk);
        chk("c_gnt", c_gnt, eg_c);
        chk("x_gnt", x_gnt, eg_x);
        chk("c_stall", c_stall, c_req && !eg_c);
        chk("m_en", m_en, eg_c || eg_x);
        chk("m_addr", m_addr, ea);
        chk("m_we", m_we, eg_c ? c_we : (eg_x ? x_we : 1'b0));
        chk("m_wdata", m_wdata, eg_c ? c_wdata : (eg_x ? x_wdata : '0));
        chk("c_rvalid", c_rvalid, mdl_pend_c);
        chk("x_rvalid", x_rvalid, mdl_pend_x);
        if (mdl_pend_c) chk("c_rdata", c_rdata, mdl_data_c);
        if (mdl_pend_x) chk("x_rdata", x_rdata, mdl_data_x);
        @(posedge clk);
        mdl_pend_c = 1'b0;
        mdl_pend_x = 1'b0;
        if (eg_c) begin
            if (c_we) ref_mem[c_addr[5:0]] = c_wdata;
            else begin mdl_pend_c = 1'b1; mdl_data_c = ref_mem[c_addr[5:0]]; end
        end
        if (eg_x) begin
            if (x_we) ref_mem[x_addr[5:0]] = x_wdata;
            else begin mdl_pend_x = 1'b1; mdl_data_x = ref_mem[x_addr[5:0]]; end
        end
        if (eg_c || eg_x) mdl_last_x = eg_x;
        if (c_req && !eg_c) mdl_wait = (mdl_wait < MAX_WAIT) ? mdl_wait + 1 : MAX_WAIT;
        else                mdl_wait = 0;
        #1;
    endtask

    initial begin
        bit gc, gx;
        string pat;
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        @(posedge clk);
        #1;
        do_reset();

        // Release with both requesting: core must win first.
        c_we = 1'b0; c_addr = 32'h4; x_we = 1'b0; x_addr = 32'h8; x_lock = 1'b0;
        cycle(gc, gx);
        chk("first_after_rst_core", gc, 1);

        // Core-only load from 0x10.
        do_reset();
        preload(6'h10, 32'hDEADBEEF);
        x_req = 1'b0; c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        cycle(gc, gx);
        chk("load_gnt", gc, 1);
        c_req = 1'b0;
        cycle(gc, gx);
        chk("load_data", c_rdata, 32'hDEADBEEF);

        // Continuous contention, no lock: C X C X.
        do_reset();
        c_we = 1'b0; x_we = 1'b0; x_lock = 1'b0;
        pat = "CXCX";
        for (int i = 0; i < 4; i++) begin
            cycle(gc, gx);
            chk("rr_pattern", {gc, gx}, (pat[i] == "C") ? 2'b10 : 2'b01);
        end

        // Locked external: X X X X C X.
        do_reset();
        x_lock = 1'b1;
        pat = "XXXXCX";
        for (int i = 0; i < 6; i++) begin
            cycle(gc, gx);
            chk("lock_pattern", {gc, gx}, (pat[i] == "C") ? 2'b10 : 2'b01);
        end
        x_lock = 1'b0;

        // External write then core load of the same address.
        do_reset();
        c_req = 1'b0;
        x_we = 1'b1; x_addr = 32'h20; x_wdata = 32'h12345678;
        cycle(gc, gx);
        x_req = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h20;
        cycle(gc, gx);
        c_req = 1'b0;
        cycle(gc, gx);
        chk("wr_then_rd", c_rdata, 32'h12345678);

        // Reset pulsed while a read response is pending: it is dropped.
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        cycle(gc, gx);
        do_reset();
        c_req = 1'b0; x_req = 1'b0;
        cycle(gc, gx);

        // Randomized traffic honoring the hold-until-granted protocol.
        for (int n = 0; n < 400; n++) begin
            if (!(c_req && !gc)) begin
                c_req   = ($urandom_range(0, 2) != 0);
                c_we    = $urandom_range(0, 1);
                c_addr  = $urandom;
                c_wdata = $urandom;
            end
            if (!(x_req && !gx)) begin
                x_req   = ($urandom_range(0, 2) != 0);
                x_we    = $urandom_range(0, 1);
                x_addr  = $urandom;
                x_wdata = $urandom;
            end
            x_lock = ($urandom_range(0, 3) != 0);
            cycle(gc, gx);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
